// File: rtl/axi_llc_miss_counters.sv
// Outstanding-miss counters for the LLC hit/miss stage.
// There is one counter per (rw, hashed AXI ID). The counter is incremented when a miss
// descriptor enters the eviction/refill pipeline and decremented when that descriptor leaves it.
// While a counter is non-zero, hits with the same rw/ID must not bypass the pending miss.
// The cnt_up_i and cnt_down_i ports are packed as {id, rw, valid}, with valid in bit 0.
module axi_llc_miss_counters #(
   parameter int NumCnt   = 4,
   parameter int CntWidth = 4,
   parameter int IdWidth  = 6
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [IdWidth+1:0] cnt_up_i,
   output logic               cnt_up_ready_o,
   input  logic [IdWidth+1:0] cnt_down_i,
   input  logic [IdWidth-1:0] query_id_i,
   input  logic               query_rw_i,
   output logic               query_busy_o,
   output logic               pending_o,
   output logic               err_underflow_o
);

   localparam int IdxW = $clog2(NumCnt);
   localparam bit NumCntOk = (NumCnt >= 2) && ((NumCnt & (NumCnt - 1)) == 0);
   localparam bit IdWidthOk = (IdWidth >= IdxW);

   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic               rw;
      logic               valid;
   } cnt_t;

   cnt_t                up;
   cnt_t                down;
   logic [IdxW-1:0]     up_idx;
   logic [IdxW-1:0]     dn_idx;
   logic [IdxW-1:0]     q_idx;
   logic [CntWidth-1:0] cnt_q [2][NumCnt];
   logic                err_q;
   logic                up_acc;
   logic                dn_zero;
   logic                dn_match;

   assign up     = cnt_t'(cnt_up_i);
   assign down   = cnt_t'(cnt_down_i);
   assign up_idx = up.id[IdxW-1:0];
   assign dn_idx = down.id[IdxW-1:0];
   assign q_idx  = query_id_i[IdxW-1:0];

   // Backpressure at max so that a counter can never wrap; this is derived from registered state only.
   assign cnt_up_ready_o = (cnt_q[up.rw][up_idx] != '1);
   assign up_acc         = up.valid & cnt_up_ready_o;

   // An up and a down on the same counter cancel, so a down at zero is legal when an up accompanies it.
   assign dn_zero  = (cnt_q[down.rw][dn_idx] == '0);
   assign dn_match = up_acc && (up.rw == down.rw) && (up_idx == dn_idx);

   assign query_busy_o    = (cnt_q[query_rw_i][q_idx] != '0);
   assign err_underflow_o = err_q;

   // OR-reduce all counters for flush / idle detection.
   always_comb begin
      pending_o = 1'b0;
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NumCnt; i++) begin
            if (cnt_q[r][i] != '0) pending_o = 1'b1;
         end
      end
   end

   // Update each counter independently from its own inc/dec pair; a down at zero clamps the counter and sets the sticky error flag.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NumCnt; i++) begin
               cnt_q[r][i] <= '0;
            end
         end
         err_q <= 1'b0;
      end else begin
         for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NumCnt; i++) begin
               if (up_acc && (up.rw == r[0]) && (up_idx == IdxW'(i))) begin
                  if (!(down.valid && (down.rw == r[0]) && (dn_idx == IdxW'(i)))) begin
                     cnt_q[r][i] <= cnt_q[r][i] + CntWidth'(1);
                  end
               end else if (down.valid && (down.rw == r[0]) && (dn_idx == IdxW'(i))) begin
                  if (cnt_q[r][i] != '0) begin
                     cnt_q[r][i] <= cnt_q[r][i] - CntWidth'(1);
                  end
               end
            end
         end
         if (down.valid && dn_zero && !dn_match) begin
            err_q <= 1'b1;
         end
      end
   end

   // Parameter sanity checks, and a check that no descriptor leaves the pipeline on a zero counter.
   a_numcnt_pow2: assert property (@(posedge clk_i) NumCntOk)
      else $error("NumCnt must be a power of two and at least 2");
   a_idwidth: assert property (@(posedge clk_i) IdWidthOk)
      else $error("IdWidth must be at least clog2(NumCnt)");
   a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(down.valid && dn_zero && !dn_match))
      else $warning("miss counter underflow: down on zero counter");

endmodule

// File: tb/tb_axi_llc_miss_counters.sv
// Bench for axi_llc_miss_counters. A driver applies directed and random traffic and pushes the
// expected outputs, taken from a reference model, into a queue. A monitor pops each entry and
// compares it with the DUT outputs sampled on the same cycle.
module tb_axi_llc_miss_counters;
   localparam int NumCnt   = 4;
   localparam int CntWidth = 4;
   localparam int IdWidth  = 6;
   localparam int MaxVal   = 2**CntWidth - 1;

   logic               clk_i = 1'b0;
   logic               rst_ni;
   logic [IdWidth+1:0] cnt_up_i;
   logic [IdWidth+1:0] cnt_down_i;
   logic [IdWidth-1:0] query_id_i;
   logic               query_rw_i;
   logic               cnt_up_ready_o;
   logic               query_busy_o;
   logic               pending_o;
   logic               err_underflow_o;

   always #5 clk_i = ~clk_i;

   axi_llc_miss_counters #(
      .NumCnt  (NumCnt),
      .CntWidth(CntWidth),
      .IdWidth (IdWidth)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .cnt_up_i       (cnt_up_i),
      .cnt_up_ready_o (cnt_up_ready_o),
      .cnt_down_i     (cnt_down_i),
      .query_id_i     (query_id_i),
      .query_rw_i     (query_rw_i),
      .query_busy_o   (query_busy_o),
      .pending_o      (pending_o),
      .err_underflow_o(err_underflow_o)
   );

   typedef struct {
      logic ready;
      logic busy;
      logic pending;
      logic err;
   } exp_t;

   exp_t exp_q[$];
   int   model [2][NumCnt];
   bit   model_err;
   bit   model_known;
   int   n_checks;
   int   n_fail;
   bit   stim_done;

   task automatic chk(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus. The pushed expectation reflects the model state before the coming edge.
   task automatic step(input bit uv, input int uid, input bit urw,
                       input bit dv, input int did, input bit drw,
                       input int qid, input bit qrw, input bit rst);
      exp_t e;
      int   ui;
      int   di;
      @(negedge clk_i);
      rst_ni     = ~rst;
      cnt_up_i   = {IdWidth'(uid), urw, uv};
      cnt_down_i = {IdWidth'(did), drw, dv};
      query_id_i = IdWidth'(qid);
      query_rw_i = qrw;
      ui = uid % NumCnt;
      di = did % NumCnt;
      if (model_known) begin
         e.ready   = (model[urw][ui] < MaxVal);
         e.busy    = (model[qrw][qid % NumCnt] > 0);
         e.pending = 1'b0;
         for (int r = 0; r < 2; r++)
            for (int i = 0; i < NumCnt; i++)
               if (model[r][i] > 0) e.pending = 1'b1;
         e.err = model_err;
         exp_q.push_back(e);
      end
      if (rst) begin
         for (int r = 0; r < 2; r++)
            for (int i = 0; i < NumCnt; i++)
               model[r][i] = 0;
         model_err   = 1'b0;
         model_known = 1'b1;
      end else if (model_known) begin
         if (uv && model[urw][ui] < MaxVal) model[urw][ui] = model[urw][ui] + 1;
         if (dv) begin
            if (model[drw][di] == 0) model_err = 1'b1;
            else model[drw][di] = model[drw][di] - 1;
         end
      end
   endtask

   task automatic idle(input int qid, input bit qrw);
      step(0, 0, 0, 0, 0, 0, qid, qrw, 0);
   endtask

   // Monitor: pops one expectation per cycle and compares it with the DUT outputs.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_i);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cnt_up_ready", cnt_up_ready_o, e.ready);
            chk("query_busy", query_busy_o, e.busy);
            chk("pending", pending_o, e.pending);
            chk("err_underflow", err_underflow_o, e.err);
         end
      end
   end

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      model_known = 1'b0;
      model_err   = 1'b0;
      stim_done   = 1'b0;
      rst_ni      = 1'b0;
      cnt_up_i    = '0;
      cnt_down_i  = '0;
      query_id_i  = '0;
      query_rw_i  = 1'b0;

      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      idle(5, 0);

      // Basic up/down on a single counter
      step(1, 5, 0, 0, 0, 0, 5, 0, 0);
      idle(5, 0);
      idle(5, 1);
      step(0, 0, 0, 1, 5, 0, 5, 0, 0);
      idle(5, 0);

      // Aliasing: ids 1, 5, 9 and 13 share an index
      step(1, 1, 1, 0, 0, 0, 9, 1, 0);
      step(1, 5, 1, 0, 0, 0, 9, 1, 0);
      idle(9, 1);
      step(0, 0, 0, 1, 1, 1, 9, 1, 0);
      step(0, 0, 0, 1, 13, 1, 9, 1, 0);
      idle(9, 1);

      // Saturation: 15 accepted ups, then a held up that waits for a down
      for (int k = 0; k < 15; k++) step(1, 2, 0, 0, 0, 0, 2, 0, 0);
      step(1, 2, 0, 0, 0, 0, 2, 0, 0);
      step(1, 3, 0, 0, 0, 0, 3, 0, 0);
      step(1, 2, 0, 1, 6, 0, 2, 0, 0);
      step(1, 2, 0, 0, 0, 0, 2, 0, 0);
      step(1, 2, 0, 0, 0, 0, 2, 0, 0);
      for (int k = 0; k < 15; k++) step(0, 0, 0, 1, 2, 0, 2, 0, 0);
      idle(2, 0);

      // Simultaneous up and down on the same counter, at zero and at 3
      step(1, 0, 0, 1, 0, 0, 0, 0, 0);
      idle(0, 0);
      for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 0, 0, 0, 1, 0);
      step(1, 0, 1, 1, 4, 1, 0, 1, 0);
      idle(0, 1);
      // Up and down on different counters in the same cycle
      step(1, 1, 0, 1, 0, 1, 1, 0, 0);
      idle(0, 1);
      idle(1, 0);

      // Underflow: the error flag is sticky through later traffic until reset
      step(0, 0, 0, 1, 3, 1, 3, 1, 0);
      idle(3, 1);
      step(1, 3, 1, 0, 0, 0, 3, 1, 0);
      step(0, 0, 0, 1, 3, 1, 3, 1, 0);
      idle(3, 1);

      // Reset mid-operation with valid traffic present
      step(1, 2, 1, 0, 0, 0, 2, 1, 0);
      step(1, 2, 1, 1, 0, 1, 2, 1, 1);
      idle(2, 1);
      idle(1, 0);

      // Random traffic with occasional resets
      for (int k = 0; k < 3000; k++) begin
         step($urandom_range(0, 9) < 6, int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 9) < 4, int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 199) == 0);
      end

      repeat (3) @(negedge clk_i);
      #3;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      stim_done = 1'b1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Safety net against a stalled run
   initial begin
      #2000000;
      if (!stim_done) begin
         $display("FAIL timeout: stimulus incomplete, expected completion");
         $fatal(1, "timeout");
      end
   end

endmodule
